hash_table_lp: RTL

//  Open-addressing hash table (linear probing, tombstone delete): a parametrised successor to the chained table.

---
 rtl/hash_table_lp.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/hash_table_lp.sv
// hash_table_lp: open-addressing key/value table with linear probing and
// tombstone delete. One slot is examined per clock; commands arrive on a
// valid/ready port and each completes with a one-cycle res_valid strobe that
// carries the value, an error flag, the probe count and the occupancy.
module hash_table_lp #(
    parameter int    KEY_WIDTH      = 32,
    parameter int    VALUE_WIDTH    = 32,
    parameter int    TOTAL_ENTRY    = 16,
    parameter string HASH_ALGORITHM = "MODULUS"
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           op_valid,
    output logic                           op_ready,
    input  logic [1:0]                     op_sel,
    input  logic [KEY_WIDTH-1:0]           key_in,
    input  logic [VALUE_WIDTH-1:0]         value_in,
    output logic                           res_valid,
    output logic [VALUE_WIDTH-1:0]         value_out,
    output logic                           op_error,
    output logic [$clog2(TOTAL_ENTRY):0]   probe_count,
    output logic [$clog2(TOTAL_ENTRY):0]   used_count
);

    localparam int INDEX_WIDTH = $clog2(TOTAL_ENTRY);
    localparam int NUM_CHUNKS  = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
    localparam int PAD_WIDTH   = NUM_CHUNKS * INDEX_WIDTH;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [INDEX_WIDTH-1:0] IDX_ONE   = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0] LAST_K    = INDEX_WIDTH'(TOTAL_ENTRY - 1);
    localparam logic [INDEX_WIDTH:0]   COUNT_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_VALID = 2'd1,
        SLOT_TOMB  = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } fsm_t;

    // Home slot of a key: low index bits, or XOR of all index-sized chunks
    // (final chunk zero-padded) when folding is selected.
    function automatic logic [INDEX_WIDTH-1:0] hash_fn(input logic [KEY_WIDTH-1:0] key);
        logic [PAD_WIDTH-1:0]   padded;
        logic [INDEX_WIDTH-1:0] acc;
        padded                 = {PAD_WIDTH{1'b0}};
        padded[KEY_WIDTH-1:0]  = key;
        acc                    = {INDEX_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            acc = acc ^ padded[i*INDEX_WIDTH +: INDEX_WIDTH];
        end
        if (HASH_ALGORITHM == "XOR_FOLD") begin
            return acc;
        end else begin
            return key[INDEX_WIDTH-1:0];
        end
    endfunction

    // Storage: slot state is reset, key/value payload is not.
    slot_t                  slot_state_r [TOTAL_ENTRY];
    logic [KEY_WIDTH-1:0]   key_mem_r    [TOTAL_ENTRY];
    logic [VALUE_WIDTH-1:0] val_mem_r    [TOTAL_ENTRY];

    // Command latched at the handshake plus probe bookkeeping.
    fsm_t                   state_r;
    logic [1:0]             op_r;
    logic [KEY_WIDTH-1:0]   key_r;
    logic [VALUE_WIDTH-1:0] value_r;
    logic [INDEX_WIDTH-1:0] idx_r;
    logic [INDEX_WIDTH-1:0] k_r;
    logic                   tomb_seen_r;
    logic [INDEX_WIDTH-1:0] tomb_idx_r;

    // Per-probe decision.
    slot_t                  cur_state_s;
    logic                   cur_match_s;
    logic                   last_s;
    logic                   term_s;
    logic                   err_s;
    logic [VALUE_WIDTH-1:0] rval_s;
    logic                   kv_we_s;
    logic                   slot_we_s;
    logic [INDEX_WIDTH-1:0] wr_idx_s;
    slot_t                  slot_new_s;
    logic                   used_inc_s;
    logic                   used_dec_s;

    assign cur_state_s = slot_state_r[idx_r];
    assign cur_match_s = (cur_state_s == SLOT_VALID) && (key_mem_r[idx_r] == key_r);
    assign last_s      = (k_r == LAST_K);

    // Decide whether the slot under examination ends the operation and what
    // it writes back. A remembered tombstone (or a tombstone at the final
    // probe) is preferred over an empty slot as the insert target.
    always_comb begin
        term_s     = 1'b0;
        err_s      = 1'b0;
        rval_s     = {VALUE_WIDTH{1'b0}};
        kv_we_s    = 1'b0;
        slot_we_s  = 1'b0;
        wr_idx_s   = idx_r;
        slot_new_s = SLOT_VALID;
        used_inc_s = 1'b0;
        used_dec_s = 1'b0;
        if (state_r == ST_PROBE) begin
            case (op_r)
                OP_SEARCH: begin
                    if (cur_match_s) begin
                        term_s = 1'b1;
                        rval_s = val_mem_r[idx_r];
                    end else if ((cur_state_s == SLOT_EMPTY) || last_s) begin
                        term_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        term_s = 1'b0;
                    end
                end
                OP_DELETE: begin
                    if (cur_match_s) begin
                        term_s     = 1'b1;
                        slot_we_s  = 1'b1;
                        slot_new_s = SLOT_TOMB;
                        used_dec_s = 1'b1;
                    end else if ((cur_state_s == SLOT_EMPTY) || last_s) begin
                        term_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        term_s = 1'b0;
                    end
                end
                OP_INSERT: begin
                    if (cur_match_s) begin
                        term_s  = 1'b1;
                        kv_we_s = 1'b1;
                    end else if ((cur_state_s == SLOT_EMPTY) || last_s) begin
                        term_s = 1'b1;
                        if (tomb_seen_r) begin
                            kv_we_s    = 1'b1;
                            slot_we_s  = 1'b1;
                            wr_idx_s   = tomb_idx_r;
                            used_inc_s = 1'b1;
                        end else if (cur_state_s != SLOT_VALID) begin
                            kv_we_s    = 1'b1;
                            slot_we_s  = 1'b1;
                            used_inc_s = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        term_s = 1'b0;
                    end
                end
                default: begin
                    term_s = 1'b1;
                end
            endcase
        end else begin
            term_s = 1'b0;
        end
    end

    // Key/value payload write for inserts and updates.
    always_ff @(posedge clk) begin
        if (kv_we_s) begin
            key_mem_r[wr_idx_s] <= key_r;
            val_mem_r[wr_idx_s] <= value_r;
        end
    end

    // Control FSM: command capture, probe walk, slot-state and occupancy
    // updates, and the registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_INSERT;
            key_r       <= {KEY_WIDTH{1'b0}};
            value_r     <= {VALUE_WIDTH{1'b0}};
            idx_r       <= {INDEX_WIDTH{1'b0}};
            k_r         <= {INDEX_WIDTH{1'b0}};
            tomb_seen_r <= 1'b0;
            tomb_idx_r  <= {INDEX_WIDTH{1'b0}};
            op_ready    <= 1'b1;
            res_valid   <= 1'b0;
            value_out   <= {VALUE_WIDTH{1'b0}};
            op_error    <= 1'b0;
            probe_count <= {(INDEX_WIDTH+1){1'b0}};
            used_count  <= {(INDEX_WIDTH+1){1'b0}};
            for (int i = 0; i < TOTAL_ENTRY; i++) begin
                slot_state_r[i] <= SLOT_EMPTY;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    res_valid <= 1'b0;
                    if (op_valid) begin
                        op_ready    <= 1'b0;
                        op_r        <= op_sel;
                        key_r       <= key_in;
                        value_r     <= value_in;
                        idx_r       <= hash_fn(key_in);
                        k_r         <= {INDEX_WIDTH{1'b0}};
                        tomb_seen_r <= 1'b0;
                        state_r     <= (op_sel == OP_CLEAR) ? ST_CLEAR : ST_PROBE;
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < TOTAL_ENTRY; i++) begin
                        slot_state_r[i] <= SLOT_EMPTY;
                    end
                    used_count  <= {(INDEX_WIDTH+1){1'b0}};
                    value_out   <= {VALUE_WIDTH{1'b0}};
                    op_error    <= 1'b0;
                    probe_count <= {(INDEX_WIDTH+1){1'b0}};
                    res_valid   <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_PROBE: begin
                    if (term_s) begin
                        if (slot_we_s) begin
                            slot_state_r[wr_idx_s] <= slot_new_s;
                        end
                        if (used_inc_s) begin
                            used_count <= used_count + COUNT_ONE;
                        end else if (used_dec_s) begin
                            used_count <= used_count - COUNT_ONE;
                        end
                        value_out   <= rval_s;
                        op_error    <= err_s;
                        probe_count <= {1'b0, k_r} + COUNT_ONE;
                        res_valid   <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        if (!tomb_seen_r && (cur_state_s == SLOT_TOMB)) begin
                            tomb_seen_r <= 1'b1;
                            tomb_idx_r  <= idx_r;
                        end
                        idx_r <= idx_r + IDX_ONE;
                        k_r   <= k_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
